handshake_cmpi_pipelined: RTL and testbench

// - Elastic integer comparator: joins lhs/rhs tokens and applies a compile-time predicate
//   (eq/ne/signed/unsigned ordering), producing a 1-bit result token.
// - The result passes through LATENCY registered, bubble-collapsing pipeline stages.
// - Next-generation cmpi for dataflow circuits where comparator delay must be cut off the

---
 rtl/handshake_cmpi_pkg.sv | 60 ++++++
 rtl/handshake_pipe_stage.sv | 42 ++++
 rtl/join_type.sv | 24 ++
 rtl/handshake_cmpi_pipelined.sv | 94 +++++++++
 tb/tb_handshake_cmpi_pipelined.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_cmpi_pkg.sv
`default_nettype none
// ============================================================================
// Module : handshake_cmpi_pkg
// Brief  : Predicate encodings and shared integer-compare evaluation.
// Rev    : 1.0 - initial release
// ============================================================================
package handshake_cmpi_pkg;

    localparam logic [3:0] CMPI_EQ  = 4'd0;
    localparam logic [3:0] CMPI_NE  = 4'd1;
    localparam logic [3:0] CMPI_SLT = 4'd2;
    localparam logic [3:0] CMPI_SLE = 4'd3;
    localparam logic [3:0] CMPI_SGT = 4'd4;
    localparam logic [3:0] CMPI_SGE = 4'd5;
    localparam logic [3:0] CMPI_ULT = 4'd6;
    localparam logic [3:0] CMPI_ULE = 4'd7;
    localparam logic [3:0] CMPI_UGT = 4'd8;
    localparam logic [3:0] CMPI_UGE = 4'd9;

    localparam int c_CMPI_MAX_WIDTH = 64;

    // Operands arrive zero-extended; width selects which bit acts as the sign.
    function automatic logic cmpi_eval(
        input logic [3:0]                  pred,
        input logic [c_CMPI_MAX_WIDTH-1:0] lhs,
        input logic [c_CMPI_MAX_WIDTH-1:0] rhs,
        input logic [6:0]                  width
    );
        logic [c_CMPI_MAX_WIDTH-1:0] w_msb;
        logic w_lsgn;
        logic w_rsgn;
        logic w_eq;
        logic w_ult;
        logic w_slt;
        logic w_res;
        w_msb  = 64'd1 << (width - 7'd1);
        w_lsgn = |(lhs & w_msb);
        w_rsgn = |(rhs & w_msb);
        w_eq   = (lhs == rhs);
        w_ult  = (lhs < rhs);
        // Same sign: magnitude order equals two's-complement order.
        w_slt  = (w_lsgn != w_rsgn) ? w_lsgn : w_ult;
        case (pred)
            CMPI_EQ:  w_res = w_eq;
            CMPI_NE:  w_res = !w_eq;
            CMPI_SLT: w_res = w_slt;
            CMPI_SLE: w_res = w_slt | w_eq;
            CMPI_SGT: w_res = !(w_slt | w_eq);
            CMPI_SGE: w_res = !w_slt;
            CMPI_ULT: w_res = w_ult;
            CMPI_ULE: w_res = w_ult | w_eq;
            CMPI_UGT: w_res = !(w_ult | w_eq);
            CMPI_UGE: w_res = !w_ult;
            default:  w_res = 1'b0;
        endcase
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/handshake_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : handshake_pipe_stage
// Brief  : Bubble-collapsing valid/data register with enable chain in/out.
// Rev    : 1.0 - initial release
// ============================================================================
module handshake_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en_next,
    output logic             o_en,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // An empty stage can always absorb, even while downstream is stalled.
    assign o_en = !r_valid | i_en_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/join_type.sv
`default_nettype none
// ============================================================================
// Module : join_type
// Brief  : N-input valid/ready join; each input is ready only when all others
//          are valid and the output is ready.
// Rev    : 1.0 - initial release
// ============================================================================
module join_type #(
    parameter int SIZE = 2
) (
    input  logic [SIZE-1:0] i_ins_valid,
    input  logic            i_outs_ready,
    output logic            o_outs_valid,
    output logic [SIZE-1:0] o_ins_ready
);

    assign o_outs_valid = &i_ins_valid;

    for (genvar i = 0; i < SIZE; i++) begin : g_ready
        assign o_ins_ready[i] = i_outs_ready & (&(i_ins_valid | (SIZE'(1) << i)));
    end

endmodule
`default_nettype wire

// File: rtl/handshake_cmpi_pipelined.sv
`default_nettype none
// ============================================================================
// Module : handshake_cmpi_pipelined
// Brief  : Elastic integer comparator with LATENCY bubble-collapsing stages.
// Rev    : 1.0 - initial release
// ============================================================================
module handshake_cmpi_pipelined
    import handshake_cmpi_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int PREDICATE = 0,
    parameter int LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    input  logic                 result_ready,
    output logic                 result,
    output logic                 result_valid,
    output logic                 lhs_ready,
    output logic                 rhs_ready
);

    localparam logic [3:0] c_PRED  = 4'(PREDICATE);
    localparam logic [6:0] c_WIDTH = 7'(DATA_TYPE);

    if ((PREDICATE < 0) || (PREDICATE > 9) || (LATENCY < 1) || (LATENCY > 8) ||
        (DATA_TYPE < 1) || (DATA_TYPE > c_CMPI_MAX_WIDTH)) begin : g_param_check
        $error("handshake_cmpi_pipelined: illegal PREDICATE/LATENCY/DATA_TYPE");
    end

    logic               w_accept;
    logic               w_join_valid;
    logic [1:0]         w_join_ready;
    logic               w_fire;
    logic               w_cmp;
    logic [LATENCY-1:0] w_v;
    logic [LATENCY-1:0] w_r;

    join_type #(.SIZE(2)) u_join (
        .i_ins_valid  ({rhs_valid, lhs_valid}),
        .i_outs_ready (w_accept),
        .o_outs_valid (w_join_valid),
        .o_ins_ready  (w_join_ready)
    );

    assign lhs_ready = w_join_ready[0];
    assign rhs_ready = w_join_ready[1];
    assign w_fire    = w_join_valid & w_accept;
    assign w_cmp     = cmpi_eval(c_PRED, 64'(lhs), 64'(rhs), c_WIDTH);

    // Each stage holds its own enable so the ready chain never feeds back
    // through a shared vector.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic w_en;
        logic w_en_next;
        logic w_in_valid;
        logic w_in_data;

        if (k == LATENCY - 1) begin : g_tail
            assign w_en_next = result_ready;
        end else begin : g_link
            assign w_en_next = g_stage[k + 1].w_en;
        end

        if (k == 0) begin : g_head
            assign w_in_valid = w_fire;
            assign w_in_data  = w_cmp;
        end else begin : g_body
            assign w_in_valid = w_v[k - 1];
            assign w_in_data  = w_r[k - 1];
        end

        handshake_pipe_stage #(.WIDTH(1)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_en_next (w_en_next),
            .o_en      (w_en),
            .i_valid   (w_in_valid),
            .i_data    (w_in_data),
            .o_valid   (w_v[k]),
            .o_data    (w_r[k])
        );
    end

    assign w_accept     = g_stage[0].w_en & ~rst;
    assign result       = w_r[LATENCY-1];
    assign result_valid = w_v[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_handshake_cmpi_pipelined.sv
`default_nettype none
// ============================================================================
// Module : tb_handshake_cmpi_pipelined
// Brief  : Self-checking bench: predicate table, join, stream, stall, reset.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_handshake_cmpi_pipelined;

    localparam int c_PL = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] lhs, rhs;
    logic       lhs_valid, rhs_valid, res_ready;
    logic [9:0] sw_res, sw_vld, sw_lr, sw_rr;
    logic       p_res, p_vld, p_lr, p_rr;
    logic       q_res, q_vld, q_lr, q_rr;
    logic       d_res, d_vld, d_lr, d_rr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar p = 0; p < 10; p++) begin : g_sweep
        handshake_cmpi_pipelined #(.DATA_TYPE(8), .PREDICATE(p), .LATENCY(1)) u_dut (
            .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .rhs(rhs),
            .rhs_valid(rhs_valid), .result_ready(1'b1), .result(sw_res[p]),
            .result_valid(sw_vld[p]), .lhs_ready(sw_lr[p]), .rhs_ready(sw_rr[p]));
    end

    handshake_cmpi_pipelined #(.DATA_TYPE(8), .PREDICATE(6), .LATENCY(c_PL)) u_p (
        .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .rhs(rhs),
        .rhs_valid(rhs_valid), .result_ready(res_ready), .result(p_res),
        .result_valid(p_vld), .lhs_ready(p_lr), .rhs_ready(p_rr));

    handshake_cmpi_pipelined #(.DATA_TYPE(8), .PREDICATE(6), .LATENCY(4)) u_q (
        .clk(clk), .rst(rst), .lhs(lhs), .lhs_valid(lhs_valid), .rhs(rhs),
        .rhs_valid(rhs_valid), .result_ready(res_ready), .result(q_res),
        .result_valid(q_vld), .lhs_ready(q_lr), .rhs_ready(q_rr));

    handshake_cmpi_pipelined #(.DATA_TYPE(1), .PREDICATE(2), .LATENCY(1)) u_d (
        .clk(clk), .rst(rst), .lhs(lhs[0]), .lhs_valid(lhs_valid), .rhs(rhs[0]),
        .rhs_valid(rhs_valid), .result_ready(1'b1), .result(d_res),
        .result_valid(d_vld), .lhs_ready(d_lr), .rhs_ready(d_rr));

    typedef struct {
        logic [7:0] l;
        logic [7:0] r;
        logic [9:0] mask;
        logic       d1;
    } vec_t;

    vec_t tbl[6];

    function automatic logic ref_cmp(input int pred, input logic [7:0] a, input logic [7:0] b);
        case (pred)
            0: return a == b;
            1: return a != b;
            2: return $signed(a) <  $signed(b);
            3: return $signed(a) <= $signed(b);
            4: return $signed(a) >  $signed(b);
            5: return $signed(a) >= $signed(b);
            6: return a <  b;
            7: return a <= b;
            8: return a >  b;
            9: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_slt1(input logic a, input logic b);
        int sa, sb;
        sa = a ? -1 : 0;
        sb = b ? -1 : 0;
        return sa < sb;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(); rst = 1'b1; lhs_valid = 1'b0; rhs_valid = 1'b0; res_ready = 1'b1;
        tick();
        tick(); rst = 1'b0;
    endtask

    bit         q_exp[$];
    logic [7:0] pl, pr;
    logic [9:0] emask;
    logic       ed1, exp_acc;
    bit         bp_exp[4];

    initial begin
        tbl[0] = '{8'hFF, 8'h01, 10'h30E, 1'b0};
        tbl[1] = '{8'h80, 8'h80, 10'h2A9, 1'b0};
        tbl[2] = '{8'h7F, 8'h80, 10'h0F2, 1'b1};
        tbl[3] = '{8'h00, 8'hFF, 10'h0F2, 1'b0};
        tbl[4] = '{8'h05, 8'h03, 10'h332, 1'b0};
        tbl[5] = '{8'h01, 8'h00, 10'h332, 1'b1};

        // Reset held with both operands offered: nothing may fire.
        rst = 1'b1; lhs = 8'h01; rhs = 8'h02; lhs_valid = 1'b1; rhs_valid = 1'b1; res_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            chk("rst_vld", p_vld, 0);
            chk("rst_lr", p_lr, 0);
            chk("rst_rr", p_rr, 0);
            chk("rst_res", {p_res, q_res}, 0);
            chk("rst_sw_vld", sw_vld, 0);
        end
        for (int c = 0; c < 4; c++) begin
            tick(); rst = 1'b0; #1;
            if (c == 0) chk("first_fire_lr", {p_lr, p_rr}, 2'b11);
            if (c == 1) chk("first_sw_vld", sw_vld, 10'h3FF);
            if (c < 3) chk("first_p_vld", p_vld, 0);
            if (c == 3) chk("first_p_res", {p_vld, p_res}, 2'b11);
        end

        // Predicate table then random operands, one pair per cycle.
        do_reset();
        for (int i = 0; i <= 46; i++) begin
            tick();
            if (i < 6) begin
                lhs = tbl[i].l; rhs = tbl[i].r;
            end else begin
                lhs = 8'($urandom); rhs = 8'($urandom);
            end
            lhs_valid = (i < 46); rhs_valid = (i < 46);
            #1;
            if (i < 46) chk("sweep_ready", {sw_lr, sw_rr, d_lr, d_rr}, 22'h3FFFFF);
            if (i > 0) begin
                if (i <= 6) begin
                    emask = tbl[i-1].mask; ed1 = tbl[i-1].d1;
                end else begin
                    for (int p = 0; p < 10; p++) emask[p] = ref_cmp(p, pl, pr);
                    ed1 = ref_slt1(pl[0], pr[0]);
                end
                chk("sweep_vld", {sw_vld, d_vld}, 11'h7FF);
                chk("sweep_res", sw_res, emask);
                chk("sweep_slt1", d_res, ed1);
            end
            pl = lhs; pr = rhs;
        end

        // Join: lhs alone must not be consumed.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick();
            lhs = 8'h33; rhs = 8'h33;
            lhs_valid = (c < 6); rhs_valid = (c == 5);
            #1;
            if (c < 5) chk("join_wait", {sw_lr[0], sw_vld[0], p_lr}, 3'b000);
            if (c == 5) chk("join_fire", {sw_lr[0], sw_rr[0], p_lr, p_rr}, 4'hF);
            if (c == 6) chk("join_result", {sw_vld[0], sw_res[0]}, 2'b11);
            if (c == 7) chk("join_done", sw_vld[0], 0);
        end

        // Stream of 10 back-to-back pairs through LATENCY 3.
        do_reset();
        q_exp.delete();
        for (int c = 0; c < 14; c++) begin
            tick();
            lhs = 8'(c * 29); rhs = 8'd120;
            lhs_valid = (c < 10); rhs_valid = (c < 10);
            if (c < 10) q_exp.push_back(lhs < rhs);
            #1;
            if (c >= 3 && c <= 12) begin
                chk("stream_vld", p_vld, 1);
                chk("stream_res", p_res, q_exp.pop_front());
            end else begin
                chk("stream_idle", p_vld, 0);
            end
        end

        // Backpressure: bubble collapse admits a 3rd token, 4th waits.
        do_reset();
        bp_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 12; c++) begin
            tick();
            res_ready = (c < 2) || (c >= 7);
            lhs_valid = (c < 8); rhs_valid = (c < 8);
            case (c)
                0: begin lhs = 8'd1;   rhs = 8'd2;   end
                1: begin lhs = 8'd9;   rhs = 8'd3;   end
                2: begin lhs = 8'd0;   rhs = 8'd255; end
                default: begin lhs = 8'd200; rhs = 8'd100; end
            endcase
            #1;
            if (c < 3 || c == 7) chk("bp_accept", {p_lr, p_rr}, 2'b11);
            if (c >= 3 && c <= 6) begin
                chk("bp_blocked", {p_lr, p_rr}, 2'b00);
                chk("bp_stable", {p_vld, p_res}, 2'b11);
            end
            if (c >= 7 && c <= 10) chk("bp_drain", {p_vld, p_res}, {1'b1, bp_exp[c-7]});
            if (c == 11) chk("bp_empty", p_vld, 0);
        end

        // Reset mid-flight with 3 tokens inside the LATENCY 4 instance.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick();
            lhs = 8'd1; rhs = 8'd5;
            rst = (c == 3);
            lhs_valid = (c <= 3); rhs_valid = (c <= 3);
            #1;
            if (c == 3) chk("mid_rst_lr", {q_lr, q_rr}, 2'b00);
            if (c != 3) chk("mid_rst_vld", q_vld, 0);
        end

        // Random traffic against an occupancy/order model.
        do_reset();
        q_exp.delete();
        for (int c = 0; c < 400; c++) begin
            tick();
            lhs = 8'($urandom); rhs = 8'($urandom);
            lhs_valid = ($urandom % 4) != 0;
            rhs_valid = ($urandom % 4) != 0;
            res_ready = ($urandom % 3) != 0;
            #1;
            exp_acc = (q_exp.size() < c_PL) || res_ready;
            chk("rnd_lr", p_lr, exp_acc & rhs_valid);
            chk("rnd_rr", p_rr, exp_acc & lhs_valid);
            if (q_exp.size() == 0) begin
                chk("rnd_empty_vld", p_vld, 0);
            end else if (p_vld) begin
                chk("rnd_res", p_res, q_exp[0]);
                if (res_ready) void'(q_exp.pop_front());
            end
            if (exp_acc && lhs_valid && rhs_valid) q_exp.push_back(lhs < rhs);
        end
        for (int c = 0; c < 12; c++) begin
            tick(); lhs_valid = 1'b0; rhs_valid = 1'b0; res_ready = 1'b1; #1;
            if (p_vld) begin
                if (q_exp.size() == 0) chk("drain_extra", p_vld, 0);
                else chk("drain_res", p_res, q_exp.pop_front());
            end
        end
        chk("drain_empty", q_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
